// File: rtl/aics_pe_pkg.sv
// Shared definitions for the PE feeder datapath.
// Holds FSM states, PE control bit positions and default widths.
package aics_pe_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RES_W   = 32;
  localparam int DEF_NADDR_W = 8;
  localparam int DEF_WADDR_W = 14;
  localparam int DEF_RADDR_W = 8;

  // pe_ctl bit positions, shared with serial_pe
  localparam int CTL_FIRST = 0;
  localparam int CTL_LAST  = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fsm_t;

endpackage

// File: rtl/fc_addr_gen.sv
// Element/row/weight counters for the FC feeder.
// Ports: clr/en control, in_num/out_num config, i/o/w counters, first/row_end/last_issue flags.
module fc_addr_gen
  import aics_pe_pkg::*;
#(
  parameter int NADDR_W = DEF_NADDR_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int WADDR_W = DEF_WADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [NADDR_W:0]   in_num,
  input  logic [RADDR_W:0]   out_num,
  output logic [NADDR_W-1:0] i,
  output logic [RADDR_W-1:0] o,
  output logic [WADDR_W-1:0] w,
  output logic               first,
  output logic               row_end,
  output logic               last_issue
);

  logic [NADDR_W:0] i_max;
  logic [RADDR_W:0] o_max;
  logic             col_end;

  assign i_max      = in_num - (NADDR_W+1)'(1);
  assign o_max      = out_num - (RADDR_W+1)'(1);
  assign first      = (i == '0);
  assign row_end    = ({1'b0, i} == i_max);
  assign col_end    = ({1'b0, o} == o_max);
  assign last_issue = row_end & col_end;

  // w runs linearly over the whole matrix, so
  // o*in_num+i never has to be multiplied out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      o <= '0;
      w <= '0;
    end else if (clr) begin
      i <= '0;
      o <= '0;
      w <= '0;
    end else if (en) begin
      w <= w + WADDR_W'(1);
      if (row_end) begin
        i <= '0;
        o <= last_issue ? '0 : o + RADDR_W'(1);
      end else begin
        i <= i + NADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fc_pe_feeder.sv
// Sequencer feeding one serial_pe to compute a fully-connected layer.
// Ports: start/cfg/busy/done control, n_*/w_* SRAM reads, pe_* PE link, r_* result writes.
module fc_pe_feeder
  import aics_pe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int NADDR_W = DEF_NADDR_W,
  parameter int WADDR_W = DEF_WADDR_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NADDR_W:0]   cfg_in_num,
  input  logic [RADDR_W:0]   cfg_out_num,
  output logic               busy,
  output logic               done,
  output logic [NADDR_W-1:0] n_addr,
  input  logic [DATA_W-1:0]  n_rdata,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0]  w_rdata,
  output logic               mem_re,
  output logic [DATA_W-1:0]  pe_neuron,
  output logic [DATA_W-1:0]  pe_weight,
  output logic [1:0]         pe_ctl,
  output logic               pe_vld_i,
  input  logic [RES_W-1:0]   pe_result,
  input  logic               pe_vld_o,
  output logic               r_we,
  output logic [RADDR_W-1:0] r_addr,
  output logic [RES_W-1:0]   r_wdata
);

  fsm_t state, nxt;

  logic [NADDR_W:0]   in_num;
  logic [RADDR_W:0]   out_num;
  logic [RADDR_W:0]   rc;
  logic [NADDR_W-1:0] i;
  logic [RADDR_W-1:0] o;
  logic [WADDR_W-1:0] w;
  logic               first, row_end, last_issue;
  logic               accept, issue, run, cfg_zero, rc_last;
  logic               s1_vld, s1_first, s1_last;

  assign accept   = (state == IDLE) & start;
  assign issue    = (state == ISSUE);
  assign run      = (state == ISSUE) | (state == DRAIN);
  assign cfg_zero = (cfg_in_num == '0) | (cfg_out_num == '0);
  assign rc_last  = (rc == out_num - (RADDR_W+1)'(1));

  fc_addr_gen #(
    .NADDR_W (NADDR_W),
    .RADDR_W (RADDR_W),
    .WADDR_W (WADDR_W)
  ) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .en         (issue),
    .in_num     (in_num),
    .out_num    (out_num),
    .i          (i),
    .o          (o),
    .w          (w),
    .first      (first),
    .row_end    (row_end),
    .last_issue (last_issue)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = cfg_zero ? DONE : ISSUE;
      ISSUE:   if (last_issue) nxt = DRAIN;
      // leave on the final write so done lands one cycle later
      DRAIN:   if (r_we && rc_last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_num  <= '0;
      out_num <= '0;
      rc      <= '0;
    end else begin
      if (accept) begin
        in_num  <= cfg_in_num;
        out_num <= cfg_out_num;
      end
      if (accept) rc <= '0;
      else if (r_we) rc <= rc + (RADDR_W+1)'(1);
    end
  end

  // control bits ride one stage so they line up with SRAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_vld   <= issue;
      s1_first <= issue & first;
      s1_last  <= issue & row_end;
    end
  end

  always_comb begin
    pe_ctl            = '0;
    pe_ctl[CTL_FIRST] = s1_first;
    pe_ctl[CTL_LAST]  = s1_last;
  end

  // busy covers the accepting cycle too
  assign busy      = run | accept;
  assign done      = (state == DONE);
  assign mem_re    = issue;
  assign n_addr    = i;
  assign w_addr    = w;
  assign pe_vld_i  = s1_vld;
  assign pe_neuron = s1_vld ? n_rdata : '0;
  assign pe_weight = s1_vld ? w_rdata : '0;
  assign r_we      = run & pe_vld_o;
  assign r_addr    = rc[RADDR_W-1:0];
  assign r_wdata   = r_we ? pe_result : '0;

endmodule

// File: doc/fc_pe_feeder.md
Name: fc_pe_feeder

Overview:
Sequencer that drives a single serial_pe multiply-accumulate unit to compute a fully-connected layer, out[o] = sum_i neuron[i]*weight[o*in_num+i].
- Upstream side: reads synchronous neuron and weight SRAMs (1-cycle read latency).
- PE side: streams operand pairs with first/last control bits into the PE.
- Downstream side: writes each 32-bit PE result into a result SRAM.
- Controlled by a start/done handshake from the layer controller.

Parameters:
DATA_W, 16, neuron/weight width (signed)
RES_W, 32, PE result width
NADDR_W, 8, neuron SRAM address width (max in_num = 2^NADDR_W)
WADDR_W, 14, weight SRAM address width
RADDR_W, 8, result SRAM address width (max out_num = 2^RADDR_W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; sampled only in IDLE
cfg_in_num  in  NADDR_W+1  dot-product length, latched on accepted start
cfg_out_num  in  RADDR_W+1  number of output neurons, latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
n_addr  out  NADDR_W  neuron SRAM read address
n_rdata  in  DATA_W  neuron SRAM read data (valid 1 cycle after address)
w_addr  out  WADDR_W  weight SRAM read address
w_rdata  in  DATA_W  weight SRAM read data (valid 1 cycle after address)
mem_re  out  1  read enable shared by both SRAMs
pe_neuron  out  DATA_W  to PE neuron; equals n_rdata
pe_weight  out  DATA_W  to PE weight; equals w_rdata
pe_ctl  out  2  to PE ctl; [0]=first element of dot product, [1]=last element
pe_vld_i  out  1  to PE vld_i
pe_result  in  RES_W  from PE result
pe_vld_o  in  1  from PE vld_o; result valid this cycle
r_we  out  1  result SRAM write enable
r_addr  out  RADDR_W  result SRAM write address
r_wdata  out  RES_W  result SRAM write data; equals pe_result

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- States:
  - IDLE: start -> latch config. If cfg_in_num==0 or cfg_out_num==0 -> DONE; else -> ISSUE.
  - ISSUE: one read per cycle, no bubbles, mem_re=1. Counters i (element) and o (row). After issuing i=in_num-1 of o=out_num-1 -> DRAIN.
  - DRAIN: mem_re=0; wait until the result-write counter reaches out_num -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Addressing:
  - n_addr=i.
  - w_addr is a running counter, incremented every issue and reset to 0 at start. No multiplier.
  - i wraps to 0 and o increments when i==in_num-1.
- Issue pipeline (one register stage): s1_vld<=issue, s1_first<=(i==0), s1_last<=(i==in_num-1).
  - pe_vld_i=s1_vld, pe_ctl={s1_last,s1_first}.
  - Operands are aligned with SRAM data.
  - in_num==1 -> pe_ctl=2'b11 every element.
- Latency: element issued at cycle T reaches the PE at T+1. The PE asserts pe_vld_o at T+2 for a last element.
- Result path:
  - r_we=pe_vld_o while busy; r_wdata=pe_result; r_addr=result counter rc.
  - rc increments on each write and is 0 at start.
  - pe_vld_o outside busy is ignored.
- Done timing: done is asserted the cycle after the write of rc=out_num-1. For a non-empty job, total busy cycles = in_num*out_num + 3.
- Simultaneous events: a result write and an issue in the same cycle are normal (rows overlap). start while busy is ignored.
- Reset mid-operation: everything returns to IDLE immediately. No done, no further SRAM or PE activity. The PE sees pe_vld_i=0.
- Arithmetic: counters are unsigned. Weight counter width is WADDR_W; in_num*out_num must fit in 2^WADDR_W (caller guarantees, not checked).

Decomposition:
- Shared package aics_pe_pkg holds:
  - state enum: IDLE, ISSUE, DRAIN, DONE
  - CTL_FIRST=0, CTL_LAST=1 bit positions (shared with the PE)
  - default widths
- One sub-module, fc_addr_gen: i/o/w counters, wrap logic, last-issue flag.
- FSM, pipeline stage and result writer stay in the top.

Test Plan:
1. in_num=3, out_num=2, neurons [1,2,3], weights [1,1,1,-1,2,-3], real serial_pe attached -> r_we twice: addr0=32'h6, addr1=32'hFFFFFFFA.
   - pe_ctl sequence 01,00,10,01,00,10.
   - done one cycle after the second write; busy for 9 cycles.
2. in_num=1, out_num=4, neuron[0]=5, weights [1,2,3,-4] -> pe_ctl=11 every element; results 5,10,15,-20 at addr 0..3 on consecutive cycles.
3. cfg_in_num=0 (out_num=3) -> done the cycle after start; no mem_re, pe_vld_i or r_we. Repeat with out_num=0: same result.
4. Second start pulse mid-ISSUE with different cfg -> ignored; addresses and results match the first config only; exactly one done.
5. rst_n low during ISSUE of row 1 of job 1 -> all outputs 0 asynchronously, state IDLE. A fresh start then produces correct results from addr 0.
6. Back-to-back jobs: start pulsed the cycle after done -> accepted; w_addr restarts at 0 and rc restarts at 0.
